// File: rtl/fp_add_issue_arbiter.sv
// Two-port round-robin issue front end for a shared fixed-latency FP adder.
// An ownership tag rides alongside the adder latency so each result returns to its requester.
module fp_add_issue_arbiter #(
    parameter int SIZE_EXP  = 8,
    parameter int SIZE_MANT = 23,
    parameter int LATENCY   = 4,
    parameter int MAX_OUT   = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req0_valid,
    output logic                          req0_ready,
    input  logic [SIZE_EXP+SIZE_MANT:0]   req0_a,
    input  logic [SIZE_EXP+SIZE_MANT:0]   req0_b,
    input  logic                          req0_sub,
    input  logic                          req1_valid,
    output logic                          req1_ready,
    input  logic [SIZE_EXP+SIZE_MANT:0]   req1_a,
    input  logic [SIZE_EXP+SIZE_MANT:0]   req1_b,
    input  logic                          req1_sub,
    output logic                          iss_valid,
    output logic [SIZE_EXP+SIZE_MANT:0]   iss_a,
    output logic [SIZE_EXP+SIZE_MANT:0]   iss_b,
    output logic                          iss_sub,
    output logic                          iss_eff_op,
    output logic                          iss_near,
    output logic                          iss_tag,
    input  logic [SIZE_EXP+SIZE_MANT:0]   res_in,
    output logic                          rsp0_valid,
    output logic                          rsp1_valid,
    output logic [SIZE_EXP+SIZE_MANT:0]   rsp_data,
    output logic                          busy
);
    localparam int W = 1 + SIZE_EXP + SIZE_MANT;
    localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);

    function automatic logic eff_op_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic sub);
        return a[W-1] ^ b[W-1] ^ sub;
    endfunction

    // Difference is taken one bit wider than the exponent so 0 vs all-ones cannot alias to +/-1.
    function automatic logic near_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic eff);
        logic signed [SIZE_EXP:0] diff;
        diff = $signed({1'b0, a[W-2 -: SIZE_EXP]}) - $signed({1'b0, b[W-2 -: SIZE_EXP]});
        return eff && ((diff == '0) || (diff == (SIZE_EXP+1)'(1)) || (diff == '1));
    endfunction

    logic [2:0]         cnt0, cnt1;
    logic               rr_ptr;
    logic               elig0, elig1, gnt0, gnt1, gnt_any;
    logic [W-1:0]       sel_a, sel_b;
    logic               sel_sub, sel_eff;
    logic [LATENCY-1:0] tag_vld_p, tag_own_p;

    assign elig0   = req0_valid && (cnt0 < MAX_CNT);
    assign elig1   = req1_valid && (cnt1 < MAX_CNT);
    assign gnt0    = elig0 && (!elig1 || !rr_ptr);
    assign gnt1    = elig1 && (!elig0 || rr_ptr);
    assign gnt_any = gnt0 || gnt1;

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        sel_a   = req0_a;
        sel_b   = req0_b;
        sel_sub = req0_sub;
        if (gnt1) begin
            sel_a   = req1_a;
            sel_b   = req1_b;
            sel_sub = req1_sub;
        end
        sel_eff = eff_op_f(sel_a, sel_b, sel_sub);
    end

    // Arbitration state: pointer only moves when both ports compete.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (elig0 && elig1) begin
            rr_ptr <= gnt0;
        end
    end

    // Issue stage: grant in cycle N appears on iss_* in cycle N+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid  <= 1'b0;
            iss_a      <= '0;
            iss_b      <= '0;
            iss_sub    <= 1'b0;
            iss_eff_op <= 1'b0;
            iss_near   <= 1'b0;
            iss_tag    <= 1'b0;
        end else begin
            iss_valid <= gnt_any;
            if (gnt_any) begin
                iss_a      <= sel_a;
                iss_b      <= sel_b;
                iss_sub    <= sel_sub;
                iss_eff_op <= sel_eff;
                iss_near   <= near_f(sel_a, sel_b, sel_eff);
                iss_tag    <= gnt1;
            end
        end
    end

    // Tag pipeline: last stage lines up with res_in for the matching issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_p <= '0;
            tag_own_p <= '0;
        end else begin
            tag_vld_p[0] <= iss_valid;
            tag_own_p[0] <= iss_tag;
            for (int i = 1; i < LATENCY; i++) begin
                tag_vld_p[i] <= tag_vld_p[i-1];
                tag_own_p[i] <= tag_own_p[i-1];
            end
        end
    end

    // Response stage: capture adder result and route it to its owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_data   <= '0;
        end else begin
            rsp0_valid <= tag_vld_p[LATENCY-1] && !tag_own_p[LATENCY-1];
            rsp1_valid <= tag_vld_p[LATENCY-1] &&  tag_own_p[LATENCY-1];
            if (tag_vld_p[LATENCY-1]) begin
                rsp_data <= res_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            case ({gnt0, rsp0_valid})
                2'b10:   cnt0 <= cnt0 + 3'd1;
                2'b01:   cnt0 <= cnt0 - 3'd1;
                default: cnt0 <= cnt0;
            endcase
            case ({gnt1, rsp1_valid})
                2'b10:   cnt1 <= cnt1 + 3'd1;
                2'b01:   cnt1 <= cnt1 - 3'd1;
                default: cnt1 <= cnt1;
            endcase
        end
    end

    assign busy = (|tag_vld_p) || iss_valid || rsp0_valid || rsp1_valid;

endmodule

// File: tb/tb_fp_add_issue_arbiter.sv
// Directed bench for fp_add_issue_arbiter with a behavioural delay-line adder model.
module tb_fp_add_issue_arbiter;
    localparam int SE  = 8;
    localparam int SM  = 23;
    localparam int LAT = 4;
    localparam int MO  = 3;
    localparam int W   = 1 + SE + SM;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_sub;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_sub;
    logic [W-1:0] req1_a, req1_b;
    logic         iss_valid, iss_sub, iss_eff_op, iss_near, iss_tag;
    logic [W-1:0] iss_a, iss_b, res_in, rsp_data;
    logic         rsp0_valid, rsp1_valid, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp_add_issue_arbiter #(
        .SIZE_EXP(SE), .SIZE_MANT(SM), .LATENCY(LAT), .MAX_OUT(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_sub(req1_sub),
        .iss_valid(iss_valid), .iss_a(iss_a), .iss_b(iss_b), .iss_sub(iss_sub),
        .iss_eff_op(iss_eff_op), .iss_near(iss_near), .iss_tag(iss_tag),
        .res_in(res_in), .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_data(rsp_data), .busy(busy)
    );

    // Stand-in adder: known FP sum for the first vector, integer sum otherwise.
    function automatic logic [W-1:0] fadd_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic sub);
        if (a == 32'h3F800000 && b == 32'h40000000 && !sub) return 32'h40400000;
        return a + b + W'(sub);
    endfunction

    logic [W-1:0] add_p [LAT];
    always @(posedge clk) begin
        add_p[0] <= iss_valid ? fadd_model(iss_a, iss_b, iss_sub) : '0;
        for (int i = 1; i < LAT; i++) add_p[i] <= add_p[i-1];
    end
    assign res_in = add_p[LAT-1];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Port-1 issue vectors: operands, sub, expected eff_op/near, expected model result.
    logic [W-1:0] v_a   [5] = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h00000000, 32'h7F800000};
    logic [W-1:0] v_b   [5] = '{32'h3F800000, 32'hBF800000, 32'h40800000, 32'h7F800000, 32'h00000000};
    logic         v_sub [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic         v_eff [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic         v_near[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [W-1:0] v_res [5] = '{32'h7F800001, 32'hFF800000, 32'h80000001, 32'h7F800001, 32'h7F800001};

    logic [W-1:0] b0_a [3] = '{32'h11, 32'h12, 32'h13};
    logic [W-1:0] b1_a [3] = '{32'h21, 32'h22, 32'h23};
    logic [W-1:0] burst_exp [6] = '{32'h11, 32'h21, 32'h12, 32'h22, 32'h13, 32'h23};

    initial begin
        int p0, p1;
        logic r0_exp;
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        repeat (LAT + 2) tick();

        check("rst_iss_valid", W'(iss_valid), '0);
        check("rst_busy", W'(busy), '0);
        check("rst_rsp0", W'(rsp0_valid), '0);
        check("rst_rsp1", W'(rsp1_valid), '0);
        check("rst_rsp_data", rsp_data, '0);
        check("rst_iss_a", iss_a, '0);
        check("rst_cnt0", W'(dut.cnt0), '0);
        check("rst_cnt1", W'(dut.cnt1), '0);
        check("rst_ptr", W'(dut.rr_ptr), '0);
        rst = 1'b0;
        tick();

        // Single add on port 0
        req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_sub = 1'b0;
        #1;
        check("t1_ready0", W'(req0_ready), W'(1));
        tick();
        req0_valid = 1'b0;
        #1;
        check("t1_iss_valid", W'(iss_valid), W'(1));
        check("t1_eff_op", W'(iss_eff_op), '0);
        check("t1_near", W'(iss_near), '0);
        check("t1_tag", W'(iss_tag), '0);
        check("t1_iss_a", iss_a, 32'h3F800000);
        check("t1_busy", W'(busy), W'(1));
        tick();
        check("t1_iss_pulse", W'(iss_valid), '0);
        repeat (3) tick();
        check("t1_rsp0_early", W'(rsp0_valid), '0);
        tick();
        check("t1_rsp0", W'(rsp0_valid), W'(1));
        check("t1_rsp1", W'(rsp1_valid), '0);
        check("t1_rsp_data", rsp_data, 32'h40400000);
        tick();
        check("t1_rsp0_pulse", W'(rsp0_valid), '0);
        check("t1_idle", W'(busy), '0);

        // Port 1 eff_op / near-path vectors, one issue every third cycle
        for (int t = 0; t < 22; t++) begin
            if (t % 3 == 0 && t / 3 < 5) begin
                req1_valid = 1'b1;
                req1_a = v_a[t/3]; req1_b = v_b[t/3]; req1_sub = v_sub[t/3];
            end else begin
                req1_valid = 1'b0;
            end
            #1;
            if (t % 3 == 0 && t / 3 < 5) check("t2_ready1", W'(req1_ready), W'(1));
            if (t % 3 == 1 && t / 3 < 5) begin
                check("t2_iss_valid", W'(iss_valid), W'(1));
                check("t2_eff_op", W'(iss_eff_op), W'(v_eff[t/3]));
                check("t2_near", W'(iss_near), W'(v_near[t/3]));
                check("t2_tag", W'(iss_tag), W'(1));
            end
            if (t >= 6 && (t - 6) % 3 == 0 && (t - 6) / 3 < 5) begin
                check("t2_rsp1", W'(rsp1_valid), W'(1));
                check("t2_rsp0", W'(rsp0_valid), '0);
                check("t2_rsp_data", rsp_data, v_res[(t-6)/3]);
            end
            tick();
        end
        check("t2_idle", W'(busy), '0);

        // Both ports compete: strict alternation starting at port 0
        p0 = 0; p1 = 0;
        for (int k = 0; k < 6; k++) begin
            req0_valid = (p0 < 3); req0_a = b0_a[(p0 < 3) ? p0 : 2]; req0_b = '0; req0_sub = 1'b0;
            req1_valid = (p1 < 3); req1_a = b1_a[(p1 < 3) ? p1 : 2]; req1_b = '0; req1_sub = 1'b0;
            #1;
            check("t3_ready0", W'(req0_ready), W'(k % 2 == 0));
            check("t3_ready1", W'(req1_ready), W'(k % 2 == 1));
            if (k % 2 == 0) p0++; else p1++;
            tick();
            check("t3_iss_tag", W'(iss_tag), W'(k % 2));
            check("t3_iss_a", iss_a, burst_exp[k]);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            check("t3_rsp0", W'(rsp0_valid), W'(k % 2 == 0));
            check("t3_rsp1", W'(rsp1_valid), W'(k % 2 == 1));
            check("t3_rsp_data", rsp_data, burst_exp[k]);
        end
        repeat (4) tick();
        check("t3_idle", W'(busy), '0);

        // Port 0 saturates at MAX_OUT; port 1 still served; accept+response keeps count
        p0 = 0;
        for (int t = 0; t < 10; t++) begin
            req0_valid = (t <= 8); req0_a = 32'h41 + W'(p0); req0_b = '0; req0_sub = 1'b0;
            req1_valid = (t == 3); req1_a = 32'h31; req1_b = '0; req1_sub = 1'b0;
            #1;
            r0_exp = (t < 3) || (t == 7) || (t == 8);
            check("t4_ready0", W'(req0_ready), W'(r0_exp));
            check("t4_ready1", W'(req1_ready), W'(t == 3));
            if (t == 4) check("t4_cnt0_full", W'(dut.cnt0), W'(3));
            if (t >= 6 && t <= 8) begin
                check("t4_rsp0", W'(rsp0_valid), W'(1));
                check("t4_rsp_data", rsp_data, 32'h41 + W'(t - 6));
            end
            if (t == 8) check("t4_cnt0_hold", W'(dut.cnt0), W'(2));
            if (t == 9) begin
                check("t4_cnt0_after", W'(dut.cnt0), W'(2));
                check("t4_rsp1", W'(rsp1_valid), W'(1));
                check("t4_rsp1_data", rsp_data, 32'h31);
            end
            if (r0_exp) p0++;
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (8) tick();
        check("t4_idle", W'(busy), '0);
        check("t4_cnt0_zero", W'(dut.cnt0), '0);

        // Reset with three operations in flight
        for (int t = 0; t < 3; t++) begin
            req0_valid = 1'b1; req0_a = 32'h51 + W'(t); req0_b = '0; req0_sub = 1'b0;
            #1;
            check("t5_ready0", W'(req0_ready), W'(1));
            tick();
        end
        req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t5_busy", W'(busy), '0);
        check("t5_cnt0", W'(dut.cnt0), '0);
        check("t5_cnt1", W'(dut.cnt1), '0);
        check("t5_iss_valid", W'(iss_valid), '0);
        check("t5_ptr", W'(dut.rr_ptr), '0);
        for (int t = 0; t < 8; t++) begin
            tick();
            check("t5_no_rsp0", W'(rsp0_valid), '0);
            check("t5_no_rsp1", W'(rsp1_valid), '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_add_issue_arbiter.md
Name: fp_add_issue_arbiter

Overview:
- Shares one fixed-latency pipelined dual-path FP adder between two requesters (port 0, port 1).
- Round-robin arbitration with valid/ready handshake on each request port.
- Precomputes effective operation and near/far path select for the issued operation.
- Tracks ownership of in-flight operations in a tag pipeline and returns each adder result to its originating requester.

Parameters:
- SIZE_EXP, 8, exponent field width.
- SIZE_MANT, 23, stored mantissa field width; operand width W = 1 + SIZE_EXP + SIZE_MANT.
- LATENCY, 4, adder issue-to-result latency in cycles (>= 1).
- MAX_OUT, 3, maximum in-flight operations per requester (1..7).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  request valid, port 0.
- req0_ready  out  1  request accepted when valid & ready, port 0.
- req0_a, req0_b  in  W  operands, port 0 (sign at MSB, exponent next).
- req0_sub  in  1  1 = a - b, 0 = a + b, port 0.
- req1_valid / req1_ready / req1_a / req1_b / req1_sub: same as port 0, for port 1.
- iss_valid  out  1  operation issued to adder this cycle.
- iss_a, iss_b  out  W  issued operands.
- iss_sub  out  1  issued sub bit.
- iss_eff_op  out  1  effective operation: a_sign ^ b_sign ^ sub (1 = effective subtract).
- iss_near  out  1  near-path select.
- iss_tag  out  1  owning requester.
- res_in  in  W  adder result, valid LATENCY cycles after iss_valid.
- rsp0_valid, rsp1_valid  out  1  result valid, per port.
- rsp_data  out  W  result data, shared by both response ports.
- busy  out  1  any operation in flight.

Behaviour:
- Reset: all outputs are 0, round-robin pointer = 0, outstanding counters = 0, tag pipeline cleared.
- Issue path is registered: a grant in cycle N drives iss_* in cycle N+1, holding iss_valid high for exactly one cycle.
- Eligibility: port i is eligible iff reqi_valid and cnt_i < MAX_OUT.
- reqi_ready = eligible_i and granted_i. Ready is combinational from valid, counter and pointer.
  - A requester must hold valid and data stable until accepted.
- Arbitration:
  - One grant per cycle.
  - If both ports are eligible, grant the port indicated by the pointer, then set pointer = other port.
  - If one port is eligible, grant it and leave the pointer unchanged.
  - If neither is eligible, there is no grant.
- Issued fields:
  - iss_eff_op = a_sign ^ b_sign ^ sub.
  - iss_near = iss_eff_op & (|exp_a - exp_b| <= 1). Compute the exponent difference in SIZE_EXP+1 bits with no wrap.
  - iss_tag = granted port.
- Tag pipeline: LATENCY-stage shift register of {valid, tag}. It enters with iss_valid/iss_tag.
  - At the output stage: rsp_data = res_in (registered), and rsp{tag}_valid is pulsed for one cycle.
  - Total latency from accept to rsp_valid = LATENCY + 2 cycles.
  - Responses have no backpressure; the requester must accept.
- Outstanding counters cnt_i:
  - +1 on accept by port i; -1 on rsp_i_valid.
  - Accept and response on the same port in the same cycle leaves the counter unchanged.
  - The counter never exceeds MAX_OUT and never underflows.
- busy = any tag-pipeline stage valid, or iss_valid, or any response-output register valid.
- rst mid-operation: all in-flight operations are discarded, so no rsp_valid is produced for them. Counters return to 0.
- Back-to-back: one issue per cycle sustained. Ordering is preserved per port and globally.

Test Plan:
- Reset, then port 0 alone sends a=0x3F800000, b=0x40000000, sub=0 -> iss_valid 1 cycle later, iss_eff_op=0, iss_near=0, iss_tag=0. Drive res_in=0x40400000 at issue+LATENCY -> rsp0_valid pulse with rsp_data=0x40400000 at accept+6.
- Port 1 sends a=0x40000000, b=0x3F800000, sub=1 -> iss_eff_op=1, iss_near=1 (exponent diff 1), iss_tag=1. Same operands with sub=0 and b negative (0xBF800000) -> iss_eff_op=1.
- Both ports valid continuously for 6 cycles with MAX_OUT=7 -> grants alternate 0,1,0,1,0,1 starting with port 0. Responses return in the same order to the correct ports.
- Port 0 valid continuously, responses stalled by LATENCY -> after 3 accepts req0_ready=0 until the first rsp0_valid. Port 1 is still granted during the stall.
- Assert rst while 3 operations are in flight -> no rsp*_valid afterward, busy=0 and both counters 0 the cycle after reset.
- Accept on port 0 in the same cycle as rsp0_valid with cnt0=MAX_OUT-1 -> cnt0 unchanged and ready stays asserted the next cycle.
